axis_pkt_rr_arbiter: RTL and testbench

//   Packet-granular round-robin arbiter that shares one 64-bit AXI-Stream input of the
//   64->512 width converter among NUM_SRC DMA streams. Once a source is granted, it owns the

---
 rtl/axis_pkt_rr_arbiter.sv | 109 ++++++++++
 tb/tb_axis_pkt_rr_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding the 64->512 width converter.
// A granted source owns the output until its TLAST handshake; beats are tagged with the source ID.
//
// state | meaning
// IDLE  | no grant; pick the next requester after last_grant, outputs quiet
// BUSY  | granted source passes straight through until its TLAST handshake
module axis_pkt_rr_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_W       = 2,
  parameter int CNT_W      = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_SRC-1:0]            src_enable,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC-1:0]            S_AXIS_TVALID,
  input  logic [NUM_SRC-1:0]            S_AXIS_TLAST,
  output logic [NUM_SRC-1:0]            S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  output logic                          M_AXIS_TLAST,
  input  logic                          M_AXIS_TREADY,
  output logic [ID_W-1:0]               M_AXIS_TID,
  output logic                          busy,
  output logic                          pkt_done,
  output logic [ID_W-1:0]               pkt_src,
  output logic [CNT_W-1:0]              pkt_beats
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    grant, last_grant, winner, idx;
  logic [CNT_W-1:0]   beat_cnt, beat_inc;
  logic [NUM_SRC-1:0] req;
  logic               found, hs;

  assign req      = S_AXIS_TVALID & src_enable;
  assign hs       = M_AXIS_TVALID & M_AXIS_TREADY;
  assign beat_inc = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;
  assign busy     = (state == BUSY);

  // Scan starts one past the previous winner and wraps at NUM_SRC, not at 2**ID_W.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = last_grant;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (idx == ID_W'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    M_AXIS_TDATA  = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TID    = '0;
    S_AXIS_TREADY = '0;
    case (state)
      IDLE: begin
        if (found) state_nxt = BUSY;
      end
      BUSY: begin
        M_AXIS_TDATA         = S_AXIS_TDATA[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        M_AXIS_TVALID        = S_AXIS_TVALID[grant];
        M_AXIS_TLAST         = S_AXIS_TLAST[grant];
        M_AXIS_TID           = grant;
        S_AXIS_TREADY[grant] = M_AXIS_TREADY;
        if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= ID_W'(NUM_SRC - 1);
      beat_cnt   <= '0;
      pkt_done   <= 1'b0;
      pkt_src    <= '0;
      pkt_beats  <= '0;
    end else begin
      state    <= state_nxt;
      pkt_done <= 1'b0;
      if (state == IDLE && found) begin
        grant    <= winner;
        beat_cnt <= '0;
      end
      if (hs) begin
        beat_cnt <= beat_inc;
        if (M_AXIS_TLAST) begin
          last_grant <= grant;
          pkt_done   <= 1'b1;
          pkt_src    <= grant;
          pkt_beats  <= beat_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Scoreboard bench for axis_pkt_rr_arbiter: per-source expected beat queues filled when packets
// are launched, drained against the converter-side handshakes.
module tb_axis_pkt_rr_arbiter;
  localparam int NS = 4;
  localparam int DW = 64;
  localparam int IW = 2;
  localparam int CW = 16;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [NS-1:0]    src_enable, s_tvalid, s_tlast, s_tready;
  logic [NS*DW-1:0] s_tdata;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid, m_tlast, m_tready;
  logic [IW-1:0]    m_tid, pkt_src;
  logic             busy, pkt_done;
  logic [CW-1:0]    pkt_beats;

  always #5 aclk = ~aclk;

  axis_pkt_rr_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .ID_W(IW), .CNT_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .src_enable(src_enable),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TREADY(s_tready), .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready), .M_AXIS_TID(m_tid), .busy(busy),
    .pkt_done(pkt_done), .pkt_src(pkt_src), .pkt_beats(pkt_beats)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          first;
    int            len;
  } exp_t;

  exp_t exp_q[NS][$];
  int   pkt_q[NS][$];
  int   cur_len[NS];
  int   cur_beat[NS];
  int   pkt_no[NS];
  bit   mrdy_q[$];
  int   grant_log[$];
  int   first_cyc[$];
  int   last_cyc[$];
  int   cyc, stall_cnt, n_cmp, n_err, pend_src, pend_len;
  bit   pend, gap_en;

  function automatic logic [DW-1:0] beat_data(input int s, input int p, input int b);
    return {8'(s), 24'(p), 32'(b)};
  endfunction

  function automatic bit all_idle();
    bit r = !pend;
    for (int s = 0; s < NS; s++)
      if (exp_q[s].size() != 0 || pkt_q[s].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic clear_bench();
    for (int s = 0; s < NS; s++) begin
      exp_q[s].delete();
      pkt_q[s].delete();
      cur_len[s]  = 0;
      cur_beat[s] = 0;
    end
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    mrdy_q.delete();
    m_tready = 1'b1;
    pend     = 1'b0;
  endtask

  task automatic reset_logs();
    grant_log.delete();
    first_cyc.delete();
    last_cyc.delete();
    stall_cnt = 0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_bench();
    src_enable = '1;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    reset_logs();
  endtask

  // Launch queued packets; each launch pushes every expected beat for that source.
  task automatic drive_sources();
    exp_t e;
    for (int s = 0; s < NS; s++) begin
      if (cur_len[s] == 0 && pkt_q[s].size() > 0) begin
        cur_len[s]  = pkt_q[s].pop_front();
        cur_beat[s] = 0;
        pkt_no[s]++;
        for (int b = 0; b < cur_len[s]; b++) begin
          e.data  = beat_data(s, pkt_no[s], b);
          e.last  = (b == cur_len[s] - 1);
          e.first = (b == 0);
          e.len   = cur_len[s];
          exp_q[s].push_back(e);
        end
      end
      if (cur_len[s] > 0) begin
        if (!s_tvalid[s]) s_tvalid[s] = gap_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        s_tdata[s*DW +: DW] = beat_data(s, pkt_no[s], cur_beat[s]);
        s_tlast[s]          = (cur_beat[s] == cur_len[s] - 1);
      end else begin
        s_tvalid[s]         = 1'b0;
        s_tlast[s]          = 1'b0;
        s_tdata[s*DW +: DW] = '0;
      end
    end
  endtask

  // One clock: observe at the falling edge, update sources just after the rising edge.
  task automatic step();
    logic [NS-1:0] hs, exp_rdy;
    exp_t e;
    int t;
    @(negedge aclk);
    cyc++;
    n_cmp++;
    if (pend) begin
      if (pkt_done !== 1'b1 || pkt_src !== IW'(pend_src) || pkt_beats !== CW'(pend_len)) begin
        $display("FAIL pkt_report: got done=%0b src=%0d beats=%0d, want done=1 src=%0d beats=%0d",
                 pkt_done, pkt_src, pkt_beats, pend_src, pend_len);
        n_err++;
      end
      pend = 1'b0;
    end else if (pkt_done !== 1'b0) begin
      $display("FAIL pkt_done_spurious: got %0b want 0 at cycle %0d", pkt_done, cyc);
      n_err++;
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      if (m_tvalid !== 1'b0 || s_tready !== '0) begin
        $display("FAIL idle_outputs: got m_tvalid=%0b s_tready=%b, want 0 and 0000", m_tvalid, s_tready);
        n_err++;
      end
    end else begin
      exp_rdy = '0;
      if (m_tready) exp_rdy[m_tid] = 1'b1;
      if (s_tready !== exp_rdy) begin
        $display("FAIL s_tready: got %b want %b (tid=%0d)", s_tready, exp_rdy, m_tid);
        n_err++;
      end
      if (!m_tready) stall_cnt++;
    end
    if (m_tvalid === 1'b1 && m_tready) begin
      t = int'(m_tid);
      n_cmp++;
      if (exp_q[t].size() == 0) begin
        $display("FAIL unexpected_beat: got tid=%0d data=%h, want no beat", t, m_tdata);
        n_err++;
      end else begin
        e = exp_q[t].pop_front();
        if (m_tdata !== e.data || m_tlast !== e.last) begin
          $display("FAIL beat: got data=%h last=%0b, want data=%h last=%0b", m_tdata, m_tlast, e.data, e.last);
          n_err++;
        end
        if (e.first) begin
          grant_log.push_back(t);
          first_cyc.push_back(cyc);
        end
        if (e.last) begin
          pend     = 1'b1;
          pend_src = t;
          pend_len = e.len;
          last_cyc.push_back(cyc);
        end
      end
    end
    hs = s_tvalid & s_tready;
    @(posedge aclk);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (hs[s]) begin
        cur_beat[s]++;
        s_tvalid[s] = 1'b0;
        if (cur_beat[s] == cur_len[s]) cur_len[s] = 0;
      end
    end
    drive_sources();
    if (mrdy_q.size() > 0) m_tready = mrdy_q.pop_front();
    else m_tready = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!all_idle() && n < 400) begin
      step();
      n++;
    end
    n_cmp++;
    if (!all_idle()) begin
      $display("FAIL %s_drain: got timeout after %0d cycles, want all packets delivered", name, n);
      n_err++;
      clear_bench();
    end
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    clear_bench();
    src_enable = '1;
    s_tvalid = '1;
    s_tlast  = '1;
    s_tdata  = '1;
    #1;
    n_cmp += 4;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tid !== '0) begin
      $display("FAIL reset_m: got v=%0b l=%0b d=%h id=%0d want all 0", m_tvalid, m_tlast, m_tdata, m_tid);
      n_err++;
    end
    if (s_tready !== '0) begin
      $display("FAIL reset_s_tready: got %b want 0000", s_tready);
      n_err++;
    end
    if (busy !== 1'b0 || pkt_done !== 1'b0) begin
      $display("FAIL reset_status: got busy=%0b done=%0b want 0 0", busy, pkt_done);
      n_err++;
    end
    if (pkt_src !== '0 || pkt_beats !== '0) begin
      $display("FAIL reset_pkt: got src=%0d beats=%0d want 0 0", pkt_src, pkt_beats);
      n_err++;
    end
    clear_bench();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    reset_logs();
  endtask

  task automatic test_two_sources();
    reset_logs();
    pkt_q[0].push_back(20);
    pkt_q[2].push_back(20);
    drain("two_sources");
    n_cmp++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
      $display("FAIL two_src_order: got %p want '{0,2}", grant_log);
      n_err++;
    end else begin
      n_cmp += 2;
      if (last_cyc[0] - first_cyc[0] != 19) begin
        $display("FAIL two_src_burst: got span %0d want 19", last_cyc[0] - first_cyc[0]);
        n_err++;
      end
      if (first_cyc[1] != last_cyc[0] + 2) begin
        $display("FAIL two_src_gap: got %0d want %0d", first_cyc[1], last_cyc[0] + 2);
        n_err++;
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    for (int s = 0; s < NS; s++) begin
      pkt_q[s].push_back(3);
      pkt_q[s].push_back(3);
    end
    drain("round_robin");
    n_cmp++;
    if (grant_log.size() != 8) begin
      $display("FAIL rr_count: got %0d packets want 8", grant_log.size());
      n_err++;
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (grant_log[i] != exp_g[i]) begin
          $display("FAIL rr_order[%0d]: got %0d want %0d", i, grant_log[i], exp_g[i]);
          n_err++;
        end
      end
    end
  endtask

  task automatic test_backpressure();
    reset_logs();
    pkt_q[1].push_back(8);
    mrdy_q = '{1, 1, 1, 1, 0, 0, 0, 0};
    drain("backpressure");
    n_cmp += 2;
    if (stall_cnt != 4) begin
      $display("FAIL bp_stalls: got %0d busy stall cycles want 4", stall_cnt);
      n_err++;
    end
    if (first_cyc.size() != 1 || last_cyc.size() != 1 || last_cyc[0] - first_cyc[0] != 11) begin
      $display("FAIL bp_span: got %0d packets want 1 spanning 11 cycles", first_cyc.size());
      n_err++;
    end
  endtask

  task automatic test_enable_mask();
    int n = 0;
    reset_logs();
    src_enable = 4'b1011;
    for (int s = 0; s < NS; s++) begin
      pkt_q[s].push_back(3);
      pkt_q[s].push_back(3);
    end
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[3].size() + pkt_q[0].size() +
            pkt_q[1].size() + pkt_q[3].size() != 0 || pend) && n < 200) begin
      step();
      n++;
    end
    for (int i = 0; i < 20; i++) step();
    n_cmp += 2;
    if (grant_log.size() != 6 || grant_log.sum() with (int'(item == 2)) != 0) begin
      $display("FAIL mask_grants: got %p want 6 packets none from src2", grant_log);
      n_err++;
    end
    if (exp_q[2].size() != 3) begin
      $display("FAIL mask_src2_pending: got %0d beats queued want 3", exp_q[2].size());
      n_err++;
    end
    src_enable = '1;
    drain("mask_release");
    reset_logs();
    pkt_q[3].push_back(6);
    n = 0;
    while (exp_q[3].size() != 3 && n < 50) begin
      step();
      n++;
    end
    src_enable[3] = 1'b0;
    drain("mask_midpkt");
    n_cmp++;
    if (grant_log.size() != 1 || grant_log[0] != 3 || last_cyc[0] - first_cyc[0] != 5) begin
      $display("FAIL mask_midpkt: got grants %p want '{3} completed in 6 beats", grant_log);
      n_err++;
    end
    pkt_q[3].push_back(1);
    repeat (10) step();
    n_cmp++;
    if (exp_q[3].size() != 1 || busy !== 1'b0) begin
      $display("FAIL mask_future: got pending=%0d busy=%0b want 1 0", exp_q[3].size(), busy);
      n_err++;
    end
    src_enable = '1;
    drain("mask_restore");
  endtask

  task automatic test_reset_midpkt();
    int n = 0;
    pkt_q[0].push_back(2);
    drain("rst_pre");
    reset_logs();
    pkt_q[1].push_back(10);
    while (exp_q[1].size() != 5 && n < 50) begin
      step();
      n++;
    end
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tid !== '0 || s_tready !== '0 ||
        busy !== 1'b0 || pkt_done !== 1'b0 || pkt_src !== '0 || pkt_beats !== '0) begin
      $display("FAIL rst_midpkt_outputs: got v=%0b d=%h id=%0d rdy=%b busy=%0b src=%0d beats=%0d want all 0",
               m_tvalid, m_tdata, m_tid, s_tready, busy, pkt_src, pkt_beats);
      n_err++;
    end
    clear_bench();
    @(posedge aclk);
    #1 aresetn = 1'b1;
    reset_logs();
    for (int s = 0; s < NS; s++) pkt_q[s].push_back(1);
    drain("rst_after");
    n_cmp++;
    if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[3] != 3) begin
      $display("FAIL rst_rr_restart: got %p want '{0,1,2,3}", grant_log);
      n_err++;
    end
  endtask

  task automatic test_one_beat();
    reset_logs();
    pkt_q[3].push_back(1);
    pkt_q[3].push_back(1);
    drain("one_beat");
    n_cmp++;
    if (first_cyc.size() != 2 || last_cyc.size() != 2 || first_cyc[1] != last_cyc[0] + 2) begin
      $display("FAIL one_beat_gap: got %0d packets want 2 with next grant after one idle cycle", first_cyc.size());
      n_err++;
    end
  endtask

  task automatic test_valid_gaps();
    reset_logs();
    gap_en = 1'b1;
    pkt_q[1].push_back(10);
    pkt_q[0].push_back(5);
    pkt_q[1].push_back(4);
    drain("valid_gaps");
    gap_en = 1'b0;
    n_cmp++;
    if (grant_log.size() != 3) begin
      $display("FAIL gaps_packets: got %0d packets want 3", grant_log.size());
      n_err++;
    end
  endtask

  initial begin
    cyc    = 0;
    n_cmp  = 0;
    n_err  = 0;
    gap_en = 1'b0;
    for (int s = 0; s < NS; s++) pkt_no[s] = 0;
    test_reset();
    test_two_sources();
    test_round_robin();
    test_backpressure();
    test_enable_mask();
    test_reset_midpkt();
    test_one_beat();
    test_valid_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
